// File: rtl/usb_ep_tx_arbiter.sv
// rtl/usb_ep_tx_arbiter.sv - packet-level round-robin arbiter for the USB device transmit byte path
// Optional build macro USB_ARB_EP0_PRIO_EN: control endpoint EP0 always wins in IDLE and leaves rr_ptr untouched.
module usb_ep_tx_arbiter #(
   parameter int NUM_EP     = 4,
   parameter int DATA_W     = 8,
   parameter int MAX_PKT    = 64,
   parameter int IPG_CYCLES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       usb_en,
   input  logic [NUM_EP-1:0]          ep_req,
   input  logic [NUM_EP*DATA_W-1:0]   ep_data,
   input  logic [NUM_EP-1:0]          ep_last,
   output logic [NUM_EP-1:0]          ep_ready,
   output logic                       tx_valid,
   output logic [DATA_W-1:0]          tx_data,
   output logic                       tx_last,
   input  logic                       tx_ready,
   output logic [$clog2(NUM_EP)-1:0]  grant_id,
   output logic                       busy,
   output logic                       trunc_err,
   output logic [15:0]                pkt_cnt
);
   localparam int ID_W  = $clog2(NUM_EP);
   localparam int CNT_W = $clog2(MAX_PKT + 1);
   localparam int GAP_W = 4;

   typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

   state_t            state;
   logic [ID_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  byte_cnt;
   logic [GAP_W-1:0]  gap_cnt;
   logic [ID_W-1:0]   pick_id;
   logic              pick_valid;
   logic              pick_upd;
   logic              g_req;
   logic              g_last;
   logic [DATA_W-1:0] g_data;
   logic              at_limit;
   logic              beat;

   // Scan from the endpoint after the last winner, wrapping around.
   function automatic logic [ID_W:0] rr_pick(input logic [NUM_EP-1:0] req,
                                             input logic [ID_W-1:0]   ptr);
      logic [ID_W:0] res;
      int            idx;
      res = '0;
      for (int k = 1; k <= NUM_EP; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_EP) idx = idx - NUM_EP;
         if (!res[ID_W] && req[idx]) res = {1'b1, ID_W'(idx)};
      end
      return res;
   endfunction

   always_comb begin
      {pick_valid, pick_id} = rr_pick(ep_req, rr_ptr);
      pick_upd = 1'b1;
`ifdef USB_ARB_EP0_PRIO_EN
      if (ep_req[0]) begin
         pick_valid = 1'b1;
         pick_id    = '0;
         pick_upd   = 1'b0;
      end
`endif
   end

   always_comb begin
      g_req  = 1'b0;
      g_last = 1'b0;
      g_data = '0;
      for (int i = 0; i < NUM_EP; i++) begin
         if (ID_W'(i) == grant_id) begin
            g_req  = ep_req[i];
            g_last = ep_last[i];
            g_data = ep_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign at_limit = (byte_cnt == CNT_W'(MAX_PKT - 1));

   // XFER is a straight combinational passthrough of the granted endpoint.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = '0;
      tx_last  = 1'b0;
      ep_ready = '0;
      if (state == XFER) begin
         tx_valid = g_req;
         tx_data  = g_data;
         tx_last  = g_last | at_limit;
         for (int i = 0; i < NUM_EP; i++)
            ep_ready[i] = (ID_W'(i) == grant_id) & tx_ready;
      end
   end

   assign beat = tx_valid & tx_ready;
   assign busy = (state == XFER) || (state == GAP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         grant_id  <= '0;
         rr_ptr    <= ID_W'(NUM_EP - 1);
         byte_cnt  <= '0;
         gap_cnt   <= '0;
         pkt_cnt   <= '0;
         trunc_err <= 1'b0;
      end else begin
         trunc_err <= 1'b0;
         case (state)
            IDLE: begin
               if (usb_en && pick_valid) begin
                  grant_id <= pick_id;
                  if (pick_upd) rr_ptr <= pick_id;
                  byte_cnt <= '0;
                  state    <= XFER;
               end
            end
            XFER: begin
               if (beat) begin
                  if (tx_last) begin
                     byte_cnt  <= '0;
                     pkt_cnt   <= pkt_cnt + 16'd1;
                     trunc_err <= at_limit & ~g_last;
                     gap_cnt   <= '0;
                     state     <= (IPG_CYCLES == 0) ? IDLE : GAP;
                  end else begin
                     byte_cnt <= byte_cnt + CNT_W'(1);
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_W'(IPG_CYCLES - 1)) state <= IDLE;
               else gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_usb_ep_tx_arbiter.sv
// tb/tb_usb_ep_tx_arbiter.sv - randomized self-checking bench for usb_ep_tx_arbiter against a packet-level model
module tb_usb_ep_tx_arbiter;
   localparam int N    = 4;
   localparam int DW   = 8;
   localparam int MAXP = 4;
   localparam int IPG  = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           usb_en = 1'b0;
   logic           tx_ready = 1'b0;
   logic [N-1:0]   ep_req = '0;
   logic [N-1:0]   ep_last = '0;
   logic [N*DW-1:0] ep_data = '0;
   logic [N-1:0]   ep_ready;
   logic           tx_valid;
   logic [DW-1:0]  tx_data;
   logic           tx_last;
   logic [1:0]     grant_id;
   logic           busy;
   logic           trunc_err;
   logic [15:0]    pkt_cnt;

   usb_ep_tx_arbiter #(.NUM_EP(N), .DATA_W(DW), .MAX_PKT(MAXP), .IPG_CYCLES(IPG)) dut (
      .clk(clk), .rst(rst), .usb_en(usb_en), .ep_req(ep_req), .ep_data(ep_data),
      .ep_last(ep_last), .ep_ready(ep_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_last(tx_last), .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy),
      .trunc_err(trunc_err), .pkt_cnt(pkt_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] data;
      logic       last;
      logic       trunc;
   } beat_t;

   logic [8:0] epq [N][$];
   beat_t      exp_q[$];
   int         m_ptr, m_pkts, mode, gap_left;
   logic       m_trunc;
   int         ready_mode, en_mode, stall_en, scn_cyc, scn_beats, ready_ph;
   int         errors = 0;
   int         checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   // Packet stream derived from queue contents: round-robin over non-empty endpoints, cut at MAXP.
   task automatic build_expect();
      logic [8:0] cq [N][$];
      logic [8:0] b;
      beat_t      e;
      int         ptr, sel, n;
      bit         done;
      ptr = m_ptr;
      for (int i = 0; i < N; i++) cq[i] = epq[i];
      do begin
         sel = -1;
         for (int k = 1; k <= N; k++)
            if (sel < 0 && cq[(ptr + k) % N].size() > 0) sel = (ptr + k) % N;
         if (sel >= 0) begin
            n = 0;
            done = 0;
            while (!done && cq[sel].size() > 0) begin
               b = cq[sel].pop_front();
               n++;
               e.id    = sel;
               e.data  = b[7:0];
               e.last  = b[8] || (n == MAXP);
               e.trunc = (n == MAXP) && !b[8];
               exp_q.push_back(e);
               done = e.last;
            end
            ptr = sel;
         end
      end while (sel >= 0);
      m_ptr = ptr;
   endtask

   task automatic cycle();
      bit    stall, bt;
      beat_t h;
      @(negedge clk);
      case (ready_mode)
         0:       tx_ready = 1'b1;
         1:       tx_ready = (ready_ph % 2 == 0);
         default: tx_ready = ($urandom % 3 != 0);
      endcase
      ready_ph++;
      case (en_mode)
         0:       usb_en = 1'b1;
         1:       usb_en = (scn_cyc >= 5) && (scn_beats == 0);
         default: usb_en = ($urandom % 4 != 0);
      endcase
      stall = stall_en != 0 && mode == 1 && exp_q.size() > 0 && ($urandom % 4 == 0);
      for (int i = 0; i < N; i++) begin
         ep_req[i] = epq[i].size() > 0 && !(stall && i == exp_q[0].id);
         if (epq[i].size() > 0) {ep_last[i], ep_data[i*DW +: DW]} = epq[i][0];
         else {ep_last[i], ep_data[i*DW +: DW]} = 9'h0;
      end
      #1;
      check("pkt_cnt", pkt_cnt, m_pkts[15:0]);
      check("trunc_err", trunc_err, m_trunc);
      m_trunc = 1'b0;
      if (mode == 0) begin
         check("idle_busy", busy, 0);
         check("idle_valid", tx_valid, 0);
         check("idle_last", tx_last, 0);
         check("idle_data", tx_data, 0);
         check("idle_ready", ep_ready, 0);
         if (usb_en && |ep_req) mode = 1;
      end else if (mode == 2) begin
         check("gap_busy", busy, 1);
         check("gap_valid", tx_valid, 0);
         check("gap_ready", ep_ready, 0);
         gap_left--;
         if (gap_left == 0) mode = 0;
      end else if (exp_q.size() == 0) begin
         check("xfer_unexpected", 1, 0);
         mode = 0;
      end else begin
         h = exp_q[0];
         check("xfer_busy", busy, 1);
         check("xfer_valid", tx_valid, !stall);
         check("grant_id", grant_id, h.id);
         check("ep_ready", ep_ready, tx_ready ? (32'd1 << h.id) : 32'd0);
         if (!stall) begin
            check("tx_data", tx_data, h.data);
            check("tx_last", tx_last, h.last);
         end
         bt = !stall && tx_ready;
         if (bt) begin
            void'(exp_q.pop_front());
            void'(epq[h.id].pop_front());
            scn_beats++;
            if (h.last) begin
               m_pkts++;
               m_trunc  = h.trunc;
               gap_left = IPG;
               mode     = (IPG > 0) ? 2 : 0;
            end
         end
      end
      scn_cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_valid", tx_valid, 0);
      check("rst_last", tx_last, 0);
      check("rst_data", tx_data, 0);
      check("rst_ready", ep_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_trunc", trunc_err, 0);
      check("rst_pkt_cnt", pkt_cnt, 0);
      check("rst_grant", grant_id, 0);
      for (int i = 0; i < N; i++) epq[i].delete();
      exp_q.delete();
      ep_req = '0;
      mode = 0; m_ptr = N - 1; m_pkts = 0; m_trunc = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic run_scn(input int bound);
      int n;
      n = 0;
      scn_cyc = 0;
      scn_beats = 0;
      build_expect();
      while (!(exp_q.size() == 0 && mode == 0) && n < bound) begin
         cycle();
         n++;
      end
      check("drained", exp_q.size(), 0);
      repeat (2) cycle();
   endtask

   task automatic push_pkt(input int id, input int len, input logic [7:0] base);
      for (int i = 0; i < len; i++)
         epq[id].push_back({(i == len - 1) ? 1'b1 : 1'b0, 8'(base + 8'(i))});
   endtask

   initial begin
      int n, len;
      ready_mode = 0; en_mode = 0; stall_en = 0; ready_ph = 0;
      #1 rst = 1'b1;
      do_reset();

      push_pkt(0, 3, 8'h11);
      epq[0][1][7:0] = 8'h22;
      epq[0][2][7:0] = 8'h33;
      run_scn(50);

      do_reset();
      for (int i = 0; i < N; i++) push_pkt(i, 1, 8'(8'hA0 + i));
      push_pkt(0, 1, 8'hA4);
      run_scn(100);

      push_pkt(2, 6, 8'h30);
      run_scn(100);

      ready_mode = 1;
      push_pkt(3, 4, 8'h50);
      run_scn(100);

      ready_mode = 0;
      en_mode = 1;
      push_pkt(1, 4, 8'h60);
      run_scn(100);

      en_mode = 0;
      push_pkt(0, 5, 8'h70);
      build_expect();
      scn_cyc = 0; scn_beats = 0; n = 0;
      while (scn_beats < 2 && n < 50) begin
         cycle();
         n++;
      end
      check("pre_reset_beats", scn_beats, 2);
      do_reset();
      push_pkt(1, 1, 8'h81);
      push_pkt(0, 1, 8'h80);
      run_scn(100);

      ready_mode = 2; en_mode = 2; stall_en = 1;
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < N; i++) begin
            if ($urandom % 2 == 1) begin
               len = 1 + int'($urandom % 9);
               for (int j = 0; j < len; j++)
                  epq[i].push_back({(j == len - 1 || $urandom % 4 == 0) ? 1'b1 : 1'b0, 8'($urandom)});
            end
         end
         run_scn(2000);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/usb_ep_tx_arbiter.md
Name: usb_ep_tx_arbiter

Overview:
Packet-level arbiter that shares the single USB device transmit byte path between NUM_EP endpoint sources.
- Grants one endpoint for a whole packet using round-robin selection.
- Enforces a maximum packet length and an inter-packet gap.
- Sits between the endpoint buffers and the device byte serializer and reports grant and status to the device controller.

Parameters:
NUM_EP, 4, number of endpoint requesters (2..8)
DATA_W, 8, byte width of data paths
MAX_PKT, 64, maximum bytes per granted packet (1..1023)
IPG_CYCLES, 2, idle cycles forced between packets (0..15)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
usb_en  input  1  bus enable; no new grant while low
ep_req  input  NUM_EP  per-endpoint byte valid / packet request
ep_data  input  NUM_EP*DATA_W  per-endpoint byte; endpoint i at bits [i*DATA_W +: DATA_W]
ep_last  input  NUM_EP  per-endpoint last-byte-of-packet flag
ep_ready  output  NUM_EP  per-endpoint byte accepted
tx_valid  output  1  byte valid to serializer
tx_data  output  DATA_W  byte to serializer
tx_last  output  1  last byte of packet
tx_ready  input  1  serializer accepts byte
grant_id  output  clog2(NUM_EP)  currently/last granted endpoint
busy  output  1  high in XFER or GAP
trunc_err  output  1  one-cycle pulse when a packet is cut at MAX_PKT
pkt_cnt  output  16  completed packets, wraps 0xFFFF->0

Behaviour:
- Reset (async): state=IDLE; grant_id=0; rr_ptr=NUM_EP-1, so EP0 wins first; byte_cnt=0; gap_cnt=0; pkt_cnt=0; trunc_err=0; busy=0; tx_valid=0; tx_last=0; tx_data=0; ep_ready=0.
- A byte beat is tx_valid && tx_ready.
- IDLE:
  - If usb_en and any ep_req, pick the first requesting endpoint scanning from rr_ptr+1 mod NUM_EP upward with wrap.
  - Register grant_id, set rr_ptr=grant, go to XFER.
  - Request sampled at edge t gives tx_valid at the earliest in the cycle after edge t.
- XFER: outputs are combinational passthrough of the granted endpoint (g):
  - tx_valid=ep_req[g]; tx_data=ep_data[g].
  - ep_ready[g]=tx_ready; all other ep_ready=0.
  - tx_last=ep_last[g] OR (byte_cnt==MAX_PKT-1).
  - Each beat increments byte_cnt.
  - On a beat with tx_last=1: byte_cnt:=0, pkt_cnt+1, go to GAP, or to IDLE if IPG_CYCLES=0.
  - If that beat ended on the length limit with ep_last[g]=0: trunc_err pulses high for exactly the next cycle. The endpoint's remaining bytes form a new packet on a later grant.
  - ep_req[g] low mid-packet: stall in XFER with tx_valid=0 and no timeout.
  - usb_en falling mid-packet: the packet still completes; usb_en gates only new grants.
- Outside XFER: tx_valid, tx_last, tx_data (forced 0) and all ep_ready are 0.
- GAP: gap_cnt counts IPG_CYCLES cycles, then IDLE. No grant is made in GAP.
- busy = state is XFER or GAP.
- Arbitration is evaluated only in IDLE. Simultaneous requests are resolved by round-robin only. A request that appears during XFER/GAP waits.
- Reset asserted mid-packet: immediate return to reset values. The partial packet is dropped and not counted.

Optional Feature:
USB_ARB_EP0_PRIO_EN
- Defined: in IDLE, if ep_req[0]=1, EP0 (control endpoint) is granted regardless of rr_ptr, and rr_ptr is not updated by EP0 grants.
- Undefined: EP0 takes part in plain round-robin like the other endpoints.

Test Plan:
- Reset, then ep_req=4'b0001 with a 3-byte packet 0x11,0x22,0x33 (last on 0x33), tx_ready=1 -> tx_data 0x11,0x22,0x33 on consecutive cycles, tx_last only on 0x33, pkt_cnt=1, busy high for 3+2 cycles.
- ep_req=4'b1111, each endpoint sending 1-byte packets, tx_ready=1 -> grant order 0,1,2,3,0; each grant separated by 2 idle cycles.
- MAX_PKT=4; EP2 sends 6 bytes with last on byte 6 -> first packet is 4 bytes with tx_last on byte 4 and trunc_err one pulse; second packet is 2 bytes with no trunc_err; pkt_cnt=2.
- Backpressure: tx_ready toggles 1,0,1,0 during a 4-byte packet -> ep_ready mirrors tx_ready, no byte duplicated or lost, completes in 8 cycles.
- usb_en=0 with ep_req=4'b0010 -> no tx_valid and busy=0. Raise usb_en -> grant_id=1 and the packet is sent. Drop usb_en mid-packet -> the packet finishes.
- Assert rst after 2 of 5 bytes -> all outputs at reset values immediately, pkt_cnt=0. After release, EP0 is granted first when requesting.
